// File: rtl/mul_pkg.sv
// Shared definitions for the MUL-stage accumulator: FSM state encoding and counter width.
package mul_pkg;
  localparam int CNTW = 8;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_DONE  = 1'b1
  } state_e;
endpackage

// File: rtl/mul_acc_add.sv
// Combinational accumulator adder; product is zero-extended before the add.
// Build option MUL_ACC_SAT_EN: clamp to all-ones on carry-out instead of wrapping.
module mul_acc_add
  import mul_pkg::*;
#(
  parameter int DATAWIDTH = 16,
  parameter int ACCWIDTH  = 16
) (
  input  logic [ACCWIDTH-1:0]  i_a,
  input  logic [DATAWIDTH-1:0] i_b,
  output logic [ACCWIDTH-1:0]  o_sum
);

`ifdef MUL_ACC_SAT_EN
  logic [ACCWIDTH:0] w_full;
  assign w_full = {1'b0, i_a} + (ACCWIDTH+1)'(i_b);
  // Once clamped, later adds of non-negative terms keep the result at max.
  assign o_sum  = w_full[ACCWIDTH] ? '1 : w_full[ACCWIDTH-1:0];
`else
  assign o_sum  = i_a + ACCWIDTH'(i_b);
`endif

endmodule

// File: rtl/mul_acc.sv
// Sums NUM_TERMS products per result behind a registered valid/ready output.
// Wrap vs. saturate is chosen inside mul_acc_add via MUL_ACC_SAT_EN.
module mul_acc
  import mul_pkg::*;
#(
  parameter int DATAWIDTH = 16,
  parameter int ACCWIDTH  = 16,
  parameter int NUM_TERMS = 4
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 clr,
  input  logic [DATAWIDTH-1:0] prod,
  input  logic                 prod_vld,
  output logic                 prod_rdy,
  output logic [ACCWIDTH-1:0]  acc,
  output logic                 acc_vld,
  input  logic                 acc_rdy
);

  localparam logic [CNTW-1:0] LAST = CNTW'(NUM_TERMS - 1);

  state_e              r_state;
  logic [CNTW-1:0]     r_cnt;
  logic [ACCWIDTH-1:0] r_sum;
  logic [ACCWIDTH-1:0] r_acc;
  logic [ACCWIDTH-1:0] w_add;

  mul_acc_add #(
    .DATAWIDTH (DATAWIDTH),
    .ACCWIDTH  (ACCWIDTH)
  ) u_add (
    .i_a   (r_sum),
    .i_b   (prod),
    .o_sum (w_add)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= ST_ACCUM;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_acc   <= '0;
    end else if (clr) begin
      // Abort wins over both handshakes; the last result stays on acc.
      r_state <= ST_ACCUM;
      r_cnt   <= '0;
      r_sum   <= '0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (prod_vld) begin
            if (r_cnt == LAST) begin
              r_acc   <= w_add;
              r_sum   <= '0;
              r_cnt   <= '0;
              r_state <= ST_DONE;
            end else begin
              r_sum <= w_add;
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (acc_rdy) r_state <= ST_ACCUM;
        end
        default: r_state <= ST_ACCUM;
      endcase
    end
  end

  assign prod_rdy = (r_state == ST_ACCUM);
  assign acc_vld  = (r_state == ST_DONE);
  assign acc      = r_acc;

endmodule
